// File: rtl/arcade_input_sequencer.sv
// Input front-end for the galaxian core: PS/2 key decode, joystick merge,
// Horz-orientation remap and a timed coin/start sequencer.
module arcade_input_sequencer #(
    parameter int unsigned COIN_LEN  = 1200000,
    parameter int unsigned GAP_LEN   = 600000,
    parameter int unsigned START_LEN = 1200000,
    parameter int unsigned CNT_W     = 24
) (
    input  logic        clk_sys,
    input  logic        I_RESET_N,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy0,
    input  logic [15:0] joy1,
    input  logic        horz,
    output logic [6:0]  P1_CSJUDLR,
    output logic [6:0]  P2_CSJUDLR,
    output logic        seq_busy
);

    localparam logic [CNT_W-1:0] COIN_LAST  = CNT_W'(COIN_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        COIN,
        GAP,
        START,
        HOLD
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             sel2_q, sel2_n;

    logic prev_toggle_q;
    logic primed_q;
    logic k_up_q, k_down_q, k_left_q, k_right_q;
    logic fire_sp_q, fire_ct_q;
    logic k_s1_q, k_s2_q;
    logic req1_q, req2_q;

    logic [6:0] j;
    logic       m_up, m_down, m_left, m_right, m_fire;
    logic       o_up, o_down, o_left, o_right;
    logic       req1, req2, rise1, rise2;
    logic       coin_d, start1_d, start2_d;

    // PS/2 event decode: first edge only primes the toggle reference
    always_ff @(posedge clk_sys or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            prev_toggle_q <= 1'b0;
            primed_q      <= 1'b0;
            k_up_q        <= 1'b0;
            k_down_q      <= 1'b0;
            k_left_q      <= 1'b0;
            k_right_q     <= 1'b0;
            fire_sp_q     <= 1'b0;
            fire_ct_q     <= 1'b0;
            k_s1_q        <= 1'b0;
            k_s2_q        <= 1'b0;
        end else if (!primed_q) begin
            prev_toggle_q <= ps2_key[10];
            primed_q      <= 1'b1;
        end else if (ps2_key[10] != prev_toggle_q) begin
            prev_toggle_q <= ps2_key[10];
            // Cursor keys arrive with or without the extended prefix.
            if (ps2_key[7:0] == 8'h75) k_up_q    <= ps2_key[9];
            if (ps2_key[7:0] == 8'h72) k_down_q  <= ps2_key[9];
            if (ps2_key[7:0] == 8'h6B) k_left_q  <= ps2_key[9];
            if (ps2_key[7:0] == 8'h74) k_right_q <= ps2_key[9];
            if (ps2_key[8:0] == 9'h029) fire_sp_q <= ps2_key[9];
            if (ps2_key[8:0] == 9'h014) fire_ct_q <= ps2_key[9];
            if (ps2_key[8:0] == 9'h005) k_s1_q    <= ps2_key[9];
            if (ps2_key[8:0] == 9'h006) k_s2_q    <= ps2_key[9];
        end
    end

    // Merge keyboard with both joysticks and apply the orientation remap
    always_comb begin
        j       = joy0[6:0] | joy1[6:0];
        m_up    = k_up_q    | j[3];
        m_down  = k_down_q  | j[2];
        m_left  = k_left_q  | j[1];
        m_right = k_right_q | j[0];
        m_fire  = fire_sp_q | fire_ct_q | j[4];
        req1    = k_s1_q | j[5];
        req2    = k_s2_q | j[6];
        // Request edges are only trusted once req_q holds a post-reset sample.
        rise1   = primed_q & req1 & ~req1_q;
        rise2   = primed_q & req2 & ~req2_q;
        if (horz) begin
            o_up    = m_left;
            o_down  = m_right;
            o_left  = m_down;
            o_right = m_up;
        end else begin
            o_up    = m_up;
            o_down  = m_down;
            o_left  = m_left;
            o_right = m_right;
        end
    end

    // Sequencer state, counter, selection and request history
    always_ff @(posedge clk_sys or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel2_q  <= 1'b0;
            req1_q  <= 1'b0;
            req2_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            sel2_q  <= sel2_n;
            req1_q  <= req1;
            req2_q  <= req2;
        end
    end

    // Sequencer next-state and coin/start decode
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        sel2_n   = sel2_q;
        coin_d   = 1'b0;
        start1_d = 1'b0;
        start2_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise1) begin
                    state_n = COIN;
                    cnt_n   = '0;
                    sel2_n  = 1'b0;
                end else if (rise2) begin
                    state_n = COIN;
                    cnt_n   = '0;
                    sel2_n  = 1'b1;
                end
            end
            COIN: begin
                coin_d = 1'b1;
                if (cnt_q == COIN_LAST) begin
                    state_n = GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_n = START;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            START: begin
                start1_d = ~sel2_q;
                start2_d = sel2_q;
                if (cnt_q == START_LAST) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!req1 && !req2) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Registered outputs to the core
    always_ff @(posedge clk_sys or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            P1_CSJUDLR <= '0;
            P2_CSJUDLR <= '0;
            seq_busy   <= 1'b0;
        end else begin
            P1_CSJUDLR <= {coin_d, start1_d, m_fire, o_up, o_down, o_left, o_right};
            P2_CSJUDLR <= {1'b0, start2_d, m_fire, o_up, o_down, o_left, o_right};
            seq_busy   <= (state_q != IDLE);
        end
    end

endmodule

// File: tb/tb_arcade_input_sequencer.sv
// Self-checking bench for arcade_input_sequencer with short sequencer timings.
module tb_arcade_input_sequencer;

    localparam int C = 4;
    localparam int G = 2;
    localparam int S = 3;

    logic        clk_sys = 1'b0;
    logic        I_RESET_N;
    logic [10:0] ps2_key;
    logic [15:0] joy0, joy1;
    logic        horz;
    logic [6:0]  P1_CSJUDLR, P2_CSJUDLR;
    logic        seq_busy;

    arcade_input_sequencer #(
        .COIN_LEN (C),
        .GAP_LEN  (G),
        .START_LEN(S),
        .CNT_W    (8)
    ) dut (
        .clk_sys   (clk_sys),
        .I_RESET_N (I_RESET_N),
        .ps2_key   (ps2_key),
        .joy0      (joy0),
        .joy1      (joy1),
        .horz      (horz),
        .P1_CSJUDLR(P1_CSJUDLR),
        .P2_CSJUDLR(P2_CSJUDLR),
        .seq_busy  (seq_busy)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: held-key set, request history and the sequence age
    // (edges since the sequence began; -1 when idle).
    bit       m_primed, m_prev;
    bit [7:0] m_held;   // 0 up,1 down,2 left,3 right,4 space,5 ctrl,6 F1,7 F2
    bit       m_r1q, m_r2q, m_sel2;
    int       m_age;
    logic [6:0] e_p1, e_p2;
    logic       e_busy;

    int cyc, coin_cnt, s1_cnt, s2_cnt, last_coin, first_s1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int key_index(input logic [8:0] c);
        if (c[7:0] == 8'h75) return 0;
        if (c[7:0] == 8'h72) return 1;
        if (c[7:0] == 8'h6B) return 2;
        if (c[7:0] == 8'h74) return 3;
        if (c == 9'h029) return 4;
        if (c == 9'h014) return 5;
        if (c == 9'h005) return 6;
        if (c == 9'h006) return 7;
        return -1;
    endfunction

    task automatic model_reset();
        m_primed = 0; m_prev = 0; m_held = '0;
        m_r1q = 0; m_r2q = 0; m_sel2 = 0; m_age = -1;
        e_p1 = '0; e_p2 = '0; e_busy = 1'b0;
    endtask

    task automatic model_edge();
        logic [15:0] jj;
        bit u, d, l, r, f, q1, q2, cn, st;
        bit [3:0] dir;
        int idx;
        jj = joy0 | joy1;
        u  = m_held[0] | jj[3];
        d  = m_held[1] | jj[2];
        l  = m_held[2] | jj[1];
        r  = m_held[3] | jj[0];
        f  = m_held[4] | m_held[5] | jj[4];
        q1 = m_held[6] | jj[5];
        q2 = m_held[7] | jj[6];
        dir = horz ? {l, r, d, u} : {u, d, l, r};
        cn = (m_age >= 0) && (m_age < C);
        st = (m_age >= C + G) && (m_age < C + G + S);
        e_p1   = {cn, st && !m_sel2, f, dir};
        e_p2   = {1'b0, st && m_sel2, f, dir};
        e_busy = (m_age >= 0);
        if (m_age < 0) begin
            if (m_primed && q1 && !m_r1q) begin m_age = 0; m_sel2 = 0; end
            else if (m_primed && q2 && !m_r2q) begin m_age = 0; m_sel2 = 1; end
        end else if (m_age < C + G + S) begin
            m_age++;
        end else if (!q1 && !q2) begin
            m_age = -1;
        end
        m_r1q = q1;
        m_r2q = q2;
        if (!m_primed) begin
            m_prev = ps2_key[10];
            m_primed = 1;
        end else if (ps2_key[10] != m_prev) begin
            m_prev = ps2_key[10];
            idx = key_index(ps2_key[8:0]);
            if (idx >= 0) m_held[idx] = ps2_key[9];
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_edge();
        #1;
        cyc++;
        check("p1", {25'd0, P1_CSJUDLR}, {25'd0, e_p1});
        check("p2", {25'd0, P2_CSJUDLR}, {25'd0, e_p2});
        check("busy", {31'd0, seq_busy}, {31'd0, e_busy});
        if (P1_CSJUDLR[6]) begin coin_cnt++; last_coin = cyc; end
        if (P1_CSJUDLR[5]) begin s1_cnt++; if (first_s1 == 0) first_s1 = cyc; end
        if (P2_CSJUDLR[5]) s2_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_key(input bit pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
        tick();
    endtask

    task automatic clear_counts();
        coin_cnt = 0; s1_cnt = 0; s2_cnt = 0; last_coin = 0; first_s1 = 0;
    endtask

    initial begin
        cyc = 0;
        clear_counts();
        model_reset();
        I_RESET_N = 1'b0;
        ps2_key = {1'b1, 1'b0, 9'h000};
        joy0 = '0; joy1 = '0; horz = 1'b0;
        #12;
        check("rst_p1", {25'd0, P1_CSJUDLR}, 32'd0);
        check("rst_p2", {25'd0, P2_CSJUDLR}, 32'd0);
        check("rst_busy", {31'd0, seq_busy}, 32'd0);
        I_RESET_N = 1'b1;
        ticks(3);
        check("prime_no_key", {25'd0, P1_CSJUDLR}, 32'd0);

        // Extended up-arrow press and release: two edges of latency
        ps2_key = {~ps2_key[10], 1'b1, 9'h175};
        ticks(2);
        check("key_up_set", {31'd0, P1_CSJUDLR[3]}, 32'd1);
        ps2_key = {~ps2_key[10], 1'b0, 9'h175};
        ticks(2);
        check("key_up_clr", {31'd0, P1_CSJUDLR[3]}, 32'd0);

        // Horz remap: joystick left appears as up after one edge
        horz = 1'b1; joy0 = 16'h0002;
        tick();
        check("horz_up", {31'd0, P1_CSJUDLR[3]}, 32'd1);
        check("horz_left", {31'd0, P1_CSJUDLR[1]}, 32'd0);
        check("horz_p2_up", {31'd0, P2_CSJUDLR[3]}, 32'd1);
        horz = 1'b0; joy0 = '0;
        tick();

        // F1 sequence
        clear_counts();
        send_key(1'b1, 9'h005);
        ticks(14);
        check("f1_coin_len", coin_cnt, C);
        check("f1_gap_len", first_s1 - last_coin - 1, G);
        check("f1_start_len", s1_cnt, S);
        check("f1_no_start2", s2_cnt, 0);
        check("f1_hold_busy", {31'd0, seq_busy}, 32'd1);
        send_key(1'b0, 9'h005);
        ticks(2);
        check("f1_release_idle", {31'd0, seq_busy}, 32'd0);

        // Simultaneous start requests, then a req2 edge during GAP
        clear_counts();
        joy0 = 16'h0020; joy1 = 16'h0040;
        tick();
        joy1 = '0;
        ticks(4);
        joy1 = 16'h0040;
        ticks(12);
        check("both_start1", s1_cnt, S);
        check("both_no_start2", s2_cnt, 0);
        joy0 = '0; joy1 = '0;
        ticks(3);
        check("both_idle", {31'd0, seq_busy}, 32'd0);

        // Fire keys held independently; extended ctrl is not fire
        send_key(1'b1, 9'h029);
        send_key(1'b1, 9'h014);
        send_key(1'b0, 9'h029);
        tick();
        check("fire_ctrl_held", {31'd0, P1_CSJUDLR[4]}, 32'd1);
        send_key(1'b0, 9'h014);
        tick();
        check("fire_released", {31'd0, P1_CSJUDLR[4]}, 32'd0);
        send_key(1'b1, 9'h114);
        tick();
        check("fire_ext_ctrl", {31'd0, P2_CSJUDLR[4]}, 32'd0);
        send_key(1'b0, 9'h114);

        // Reset during COIN, request still held across release
        joy0 = 16'h0020;
        ticks(4);
        check("coin_before_rst", {31'd0, P1_CSJUDLR[6]}, 32'd1);
        #2;
        I_RESET_N = 1'b0;
        #1;
        check("async_p1", {25'd0, P1_CSJUDLR}, 32'd0);
        check("async_p2", {25'd0, P2_CSJUDLR}, 32'd0);
        check("async_busy", {31'd0, seq_busy}, 32'd0);
        model_reset();
        #3;
        I_RESET_N = 1'b1;
        ticks(8);
        check("held_req_no_seq", {31'd0, seq_busy}, 32'd0);
        joy0 = '0;
        ticks(2);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                logic [8:0] codes [12];
                codes = '{9'h075, 9'h175, 9'h072, 9'h06B, 9'h174, 9'h029,
                          9'h014, 9'h114, 9'h005, 9'h006, 9'h01C, 9'h129};
                ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)),
                           codes[$urandom_range(0, 11)]};
            end
            if ($urandom_range(0, 3) == 0) begin
                joy0 = 16'($urandom) & ($urandom_range(0, 5) == 0 ? 16'hFFFF : 16'hFF9F);
                joy1 = 16'($urandom) & ($urandom_range(0, 5) == 0 ? 16'hFFFF : 16'hFF9F);
            end
            if ($urandom_range(0, 7) == 0) horz = ~horz;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
